// File: rtl/valu_logic_arbiter.sv
// Round-robin arbiter that shares one combinational logic datapath among NREQ requesters.
// Define VALU_ZERO_FLAG_EN to add the rsp_zero output.
module valu_logic_arbiter #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int WIDTH  = 32,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  input  logic [2*NREQ-1:0]     req_op,
  output logic [WIDTH-1:0]      dp_a,
  output logic [WIDTH-1:0]      dp_b,
  output logic [1:0]            dp_op,
  input  logic [WIDTH-1:0]      dp_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id
`ifdef VALU_ZERO_FLAG_EN
  ,
  output logic                  rsp_zero
`endif
);

  localparam int CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  gnt_id_q;
  logic [CW-1:0]   cnt_q;
  logic [IDW-1:0]  grant;
  logic            any_valid;

  // Search starts at the pointer; IDW-bit addition wraps mod NREQ since NREQ is a power of two.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant     = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_valid && req_valid[ptr_q + IDW'(k)]) begin
        any_valid = 1'b1;
        grant     = ptr_q + IDW'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          req_ready[grant] = 1'b1;
          state_d          = ST_SETTLE;
        end
      end
      ST_SETTLE: if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready)   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_id_q  <= '0;
      cnt_q     <= '0;
      dp_a      <= '0;
      dp_b      <= '0;
      dp_op     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
`ifdef VALU_ZERO_FLAG_EN
      rsp_zero  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (any_valid) begin
            dp_a     <= req_a[grant*WIDTH +: WIDTH];
            dp_b     <= req_b[grant*WIDTH +: WIDTH];
            dp_op    <= req_op[grant*2 +: 2];
            gnt_id_q <= grant;
            ptr_q    <= grant + IDW'(1);
            cnt_q    <= CW'(SETTLE - 1);
          end
        end
        ST_SETTLE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            rsp_data  <= dp_result;
            rsp_id    <= gnt_id_q;
            rsp_valid <= 1'b1;
`ifdef VALU_ZERO_FLAG_EN
            rsp_zero  <= (dp_result == '0);
`endif
          end
        end
        ST_RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_valu_logic_arbiter.sv
// Self-checking bench for valu_logic_arbiter: transaction-level model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_valu_logic_arbiter;

  localparam int NREQ   = 4;
  localparam int IDW    = 2;
  localparam int WIDTH  = 32;
  localparam int SETTLE = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH-1:0]      dp_a;
  logic [WIDTH-1:0]      dp_b;
  logic [1:0]            dp_op;
  logic [WIDTH-1:0]      dp_result;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
`ifdef VALU_ZERO_FLAG_EN
  logic                  rsp_zero;
`endif

  int checks   = 0;
  int failures = 0;

  valu_logic_arbiter #(.NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_op     (dp_op),
    .dp_result (dp_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef VALU_ZERO_FLAG_EN
    ,
    .rsp_zero  (rsp_zero)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] logic_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Stand-in for the shared combinational logic unit.
  assign dp_result = logic_op(dp_a, dp_b, dp_op);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // A request is accepted whenever the unit is free; its response is visible from
  // SETTLE+1 cycles after acceptance until the consumer takes it.
  bit               model_on = 1'b0;
  bit               m_busy;
  int               m_age;
  int               m_ptr;
  int               m_id;
  logic [WIDTH-1:0] m_a, m_b, m_rsp_data;
  logic [1:0]       m_op;
  int               m_rsp_id;
  bit               m_rsp_zero;

  always @(negedge clk) begin
    logic [NREQ-1:0] e_ready;
    bit              e_valid;
    int              pick;
    e_ready = '0;
    pick    = -1;
    if (!m_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        if (pick < 0 && req_valid[(m_ptr + k) % NREQ]) pick = (m_ptr + k) % NREQ;
      end
    end
    if (pick >= 0) e_ready[pick] = 1'b1;
    e_valid = m_busy && (m_age >= SETTLE + 1);

    if (model_on) begin
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      check("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      check("rsp_data", rsp_data, m_rsp_data);
      check("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
      check("dp_a", dp_a, m_a);
      check("dp_b", dp_b, m_b);
      check("dp_op", 32'(dp_op), 32'(m_op));
`ifdef VALU_ZERO_FLAG_EN
      check("rsp_zero", 32'(rsp_zero), 32'(m_rsp_zero));
`endif
    end

    if (reset) begin
      model_on   = 1'b1;
      m_busy     = 1'b0;
      m_age      = 0;
      m_ptr      = 0;
      m_id       = 0;
      m_a        = '0;
      m_b        = '0;
      m_op       = '0;
      m_rsp_data = '0;
      m_rsp_id   = 0;
      m_rsp_zero = 1'b0;
    end else begin
      if (e_valid && rsp_ready) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_age++;
        if (m_age == SETTLE + 1) begin
          m_rsp_data = logic_op(m_a, m_b, m_op);
          m_rsp_id   = m_id;
          m_rsp_zero = (m_rsp_data == '0);
        end
      end
      if (pick >= 0) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_a    = req_a[pick*WIDTH +: WIDTH];
        m_b    = req_b[pick*WIDTH +: WIDTH];
        m_op   = req_op[pick*2 +: 2];
        m_id   = pick;
        m_ptr  = (pick + 1) % NREQ;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int g_id[8];
  int g_cyc[8];
  int g_n;
  bit ok;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_op[i*2 +: 2]        = op;
  endtask

  // Returns at the negedge of the cycle in which requester idx is granted.
  task automatic wait_ready(input int idx, output bit found);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (req_ready[idx]) found = 1'b1;
      else step();
    end
  endtask

  task automatic wait_rsp(output bit found);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (rsp_valid) found = 1'b1;
      else step();
    end
  endtask

  // Records the next n grants (index and cycle offset); ends at the negedge of the last one.
  task automatic collect(input int n);
    g_n = 0;
    for (int c = 0; c < 60 && g_n < n; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g_id[g_n] = i;
        g_cyc[g_n] = c;
        g_n++;
      end
      if (g_n < n) step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    repeat (3) step();

    // Reset state
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", rsp_data, 32'h0);
    check("reset_dp_a", dp_a, 32'h0);
    step();

    // Single XOR transaction, latency SETTLE+1
    reset     = 1'b0;
    set_req(0, 32'hFFFF0000, 32'h0F0F0F0F, 2'b10);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t1_ready_c0", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t1_valid_c1", 32'(rsp_valid), 32'd0);
    step();
    step();
    @(negedge clk);
    check("t1_valid_c3", 32'(rsp_valid), 32'd1);
    check("t1_data_c3", rsp_data, 32'hF0F00F0F);
    check("t1_id_c3", 32'(rsp_id), 32'd0);
    step();
    @(negedge clk);
    check("t1_valid_c4", 32'(rsp_valid), 32'd0);
    step();

    // All four requesting: strict round-robin, one grant every SETTLE+2 cycles
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(0, 32'h11111111, 32'h0000FFFF, 2'b00);
    set_req(1, 32'h22222222, 32'h00FF00FF, 2'b01);
    set_req(2, 32'h33333333, 32'h0F0F0F0F, 2'b10);
    set_req(3, 32'h44444444, 32'h55555555, 2'b11);
    req_valid = 4'b1111;
    collect(5);
    check("rr_count", 32'(g_n), 32'd5);
    for (int k = 0; k < 5; k++) check("rr_order", 32'(g_id[k]), 32'(exp_order[k]));
    for (int k = 1; k < 5; k++) check("rr_interval", 32'(g_cyc[k] - g_cyc[k-1]), 32'(SETTLE + 2));
    step();

    // Serve requester 2, then 3 must win over 0
    req_valid = 4'b0100;
    wait_ready(2, ok);
    check("rr_grant2", 32'(ok), 32'd1);
    step();
    req_valid = 4'b1001;
    collect(2);
    check("rr_after2_count", 32'(g_n), 32'd2);
    check("rr_after2_first", 32'(g_id[0]), 32'd3);
    check("rr_after2_second", 32'(g_id[1]), 32'd0);
    step();
    req_valid = '0;
    wait_rsp(ok);
    check("rr_drain", 32'(ok), 32'd1);
    step();

    // Backpressure: response held for several cycles, nothing accepted meanwhile
    set_req(1, 32'hA5A5A5A5, 32'h0F0F0F0F, 2'b11);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    wait_ready(1, ok);
    check("bp_grant", 32'(ok), 32'd1);
    step();
    req_valid = 4'b0001;
    wait_rsp(ok);
    check("bp_rsp", 32'(ok), 32'd1);
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_data", rsp_data, 32'h50505050);
      check("bp_hold_id", 32'(rsp_id), 32'd1);
      check("bp_hold_ready", 32'(req_ready), 32'h0);
      step();
      @(negedge clk);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", 32'(rsp_valid), 32'd1);
    check("bp_hs_ready", 32'(req_ready), 32'h0);
    step();
    @(negedge clk);
    check("bp_after_valid", 32'(rsp_valid), 32'd0);
    check("bp_after_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    wait_rsp(ok);
    check("bp_drain", 32'(ok), 32'd1);
    step();

    // Reset during SETTLE aborts the operation and returns the pointer to 0
    req_valid = 4'b0010;
    wait_ready(1, ok);
    check("rst_grant1", 32'(ok), 32'd1);
    step();
    req_valid = '0;
    reset     = 1'b1;
    step();
    reset     = 1'b0;
    req_valid = 4'b0110;
    @(negedge clk);
    check("rst_no_rsp", 32'(rsp_valid), 32'd0);
    check("rst_ptr_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    wait_rsp(ok);
    check("rst_rsp", 32'(ok), 32'd1);
    check("rst_rsp_id", 32'(rsp_id), 32'd1);
    step();

`ifdef VALU_ZERO_FLAG_EN
    // Zero flag follows the captured result
    set_req(0, 32'h12345678, 32'h12345678, 2'b10);
    req_valid = 4'b0001;
    wait_ready(0, ok);
    step();
    req_valid = '0;
    wait_rsp(ok);
    check("zf_xor_data", rsp_data, 32'h0);
    check("zf_xor_zero", 32'(rsp_zero), 32'd1);
    step();
    set_req(0, 32'h12345678, 32'h12345678, 2'b01);
    req_valid = 4'b0001;
    wait_ready(0, ok);
    step();
    req_valid = '0;
    wait_rsp(ok);
    check("zf_or_data", rsp_data, 32'h12345678);
    check("zf_or_zero", 32'(rsp_zero), 32'd0);
    step();
`endif

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
